// File: rtl/wb_conmax_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// wb_conmax_pkg : shared state encoding and defaults for the master port
// Rev 1.0
// ------------------------------------------------------------------
package wb_conmax_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ERR  = 2'd2,
    ST_TOUT = 2'd3
  } state_t;

  localparam int unsigned C_AW_DEF       = 32;
  localparam int unsigned C_DW_DEF       = 32;
  localparam int unsigned C_NS_DEF       = 8;
  localparam int unsigned C_SW_IDX_DEF   = 3;
  localparam int unsigned C_TO_W_DEF     = 8;
  localparam logic [7:0]  C_TO_LIMIT_DEF = 8'd255;

  // Lowest address bit of the slave-select field at the top of the address.
  function automatic int unsigned dec_lsb(input int unsigned aw, input int unsigned idx_w);
    return aw - idx_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_conmax_to_cnt.sv
`default_nettype none
// ------------------------------------------------------------------
// wb_conmax_to_cnt : no-response wait counter with limit compare
// Rev 1.0
// ------------------------------------------------------------------
module wb_conmax_to_cnt #(
  parameter int unsigned TO_W = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            inc_i,
  input  logic [TO_W-1:0] limit_i,
  output logic            expire_o
);

  logic [TO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i)
      cnt_d = cnt_q + TO_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign expire_o = (cnt_q == limit_i);

endmodule
`default_nettype wire

// File: rtl/wb_conmax_mst_port.sv
`default_nettype none
// ------------------------------------------------------------------
// wb_conmax_mst_port : master-side port, decodes and locks a route to one slave
// Rev 1.0
// ------------------------------------------------------------------
module wb_conmax_mst_port
  import wb_conmax_pkg::*;
#(
  parameter int unsigned     aw       = C_AW_DEF,
  parameter int unsigned     dw       = C_DW_DEF,
  parameter int unsigned     sw       = dw / 8,
  parameter int unsigned     NS       = C_NS_DEF,
  parameter int unsigned     SW_IDX   = C_SW_IDX_DEF,
  parameter int unsigned     TO_W     = C_TO_W_DEF,
  parameter logic [TO_W-1:0] TO_LIMIT = C_TO_LIMIT_DEF
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [dw-1:0]  m_data_i,
  output logic [dw-1:0]  m_data_o,
  input  logic [aw-1:0]  m_addr_i,
  input  logic [sw-1:0]  m_sel_i,
  input  logic           m_we_i,
  input  logic           m_cyc_i,
  input  logic           m_stb_i,
  output logic           m_ack_o,
  output logic           m_err_o,
  output logic           m_rty_o,
  input  logic [NS-1:0]  slv_en_i,
  output logic [dw-1:0]  s_data_o,
  output logic [aw-1:0]  s_addr_o,
  output logic [sw-1:0]  s_sel_o,
  output logic           s_we_o,
  output logic [NS-1:0]  s_cyc_o,
  output logic [NS-1:0]  s_stb_o,
  input  logic [NS*dw-1:0] s_data_i,
  input  logic [NS-1:0]  s_ack_i,
  input  logic [NS-1:0]  s_err_i,
  input  logic [NS-1:0]  s_rty_i,
  output logic           tout_o
);

  localparam int unsigned C_IDX_LSB = dec_lsb(aw, SW_IDX);

  state_t            state_q, state_d;
  logic [SW_IDX-1:0] sel_q, sel_d;
  logic [SW_IDX-1:0] idx;
  logic [NS-1:0]     sel_oh;
  logic              req, resp, busy, to_expire, to_clr, to_inc;

  assign idx  = m_addr_i[aw-1:C_IDX_LSB];
  assign req  = m_cyc_i & m_stb_i;
  assign busy = (state_q == ST_BUSY);
  assign resp = s_ack_i[sel_q] | s_err_i[sel_q] | s_rty_i[sel_q];

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (slv_en_i[idx]) begin
            sel_d   = idx;
            state_d = ST_BUSY;
          end else begin
            state_d = ST_ERR;
          end
        end
      end
      // A late response in the limit cycle takes priority over the timeout.
      ST_BUSY: begin
        if (!m_cyc_i)
          state_d = ST_IDLE;
        else if (to_expire && !resp)
          state_d = ST_TOUT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  // Clearing outside BUSY guarantees a fresh count on every new route.
  assign to_clr = !busy || resp || !m_stb_i;
  assign to_inc = busy && m_stb_i && !resp;

  wb_conmax_to_cnt #(
    .TO_W (TO_W)
  ) u_to_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (to_clr),
    .inc_i    (to_inc),
    .limit_i  (TO_LIMIT),
    .expire_o (to_expire)
  );

  always_comb begin
    sel_oh        = '0;
    sel_oh[sel_q] = 1'b1;
  end

  always_comb begin
    m_data_o = '0;
    for (int k = 0; k < NS; k++)
      if (sel_q == SW_IDX'(k))
        m_data_o = s_data_i[k*dw +: dw];
  end

  assign s_data_o = m_data_i;
  assign s_addr_o = m_addr_i;
  assign s_sel_o  = m_sel_i;
  assign s_we_o   = m_we_i;

  assign s_cyc_o = (busy && m_cyc_i) ? sel_oh : '0;
  assign s_stb_o = (busy && m_stb_i) ? sel_oh : '0;

  assign m_ack_o = busy & s_ack_i[sel_q];
  assign m_rty_o = busy & s_rty_i[sel_q];
  assign m_err_o = busy ? s_err_i[sel_q]
                        : (((state_q == ST_ERR) || (state_q == ST_TOUT)) & req);
  assign tout_o  = (state_q == ST_TOUT);

endmodule
`default_nettype wire
